// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter feeding a registered single-entry valid/ready slot from four 32-bit sources.
// Optional burst grant-lock is enabled with `define MUXARB_LOCK_EN.
module mux4_rr_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [3:0]   lock,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  input  logic [W-1:0] a3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  typedef enum logic [1:0] {IDLE, FULL, LOCKED} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_ptr, r_sel, w_idx, w_cand;
  logic [W-1:0]      r_data;
  logic [3:0][W-1:0] w_src;
  logic [3:0]        w_req_m, w_gnt;
  logic              w_free, w_hit, w_lock_hit;

  assign w_src     = {a3, a2, a1, a0};
  assign out_valid = (r_state != IDLE);
  assign w_free    = !out_valid || out_ready;

`ifdef MUXARB_LOCK_EN
  logic [1:0] r_owner;

  // While locked, every requester except the owner is invisible to the search.
  always_comb begin
    w_req_m = req;
    if (r_state == LOCKED) w_req_m = req & (4'b0001 << r_owner);
  end

  assign w_lock_hit = w_hit && lock[w_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_owner <= 2'd0;
    else if (w_hit) r_owner <= w_idx;
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock;
  assign w_req_m       = req;
  assign w_lock_hit    = 1'b0;
`endif

  // Search from ptr+1 upward; k=4 wraps back onto ptr itself, which has lowest priority.
  always_comb begin
    w_gnt  = 4'b0000;
    w_idx  = r_ptr;
    w_cand = r_ptr;
    w_hit  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_hit && w_req_m[w_cand]) begin
        w_hit = 1'b1;
        w_idx = w_cand;
      end
    end
    if (!(w_free && rst_n)) w_hit = 1'b0;
    if (w_hit) w_gnt[w_idx] = 1'b1;
  end

  assign gnt = w_gnt;

  always_comb begin
    w_state_nxt = r_state;
    if (w_free) begin
      if (w_hit) w_state_nxt = w_lock_hit ? LOCKED : FULL;
      else       w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 2'd3;
      r_sel   <= 2'd0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hit) begin
        r_data <= w_src[w_idx];
        r_sel  <= w_idx;
        r_ptr  <= w_idx;
      end
    end
  end

  assign sel      = r_sel;
  assign out_data = r_data;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: reference arbiter model plus scoreboard of granted words.
module tb_mux4_rr_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req, lock, gnt;
  logic [W-1:0] a0, a1, a2, a3, out_data;
  logic [1:0]   sel;
  logic         out_valid, out_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int           m_ptr;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [1:0]   m_sel;
  logic [W+1:0] sb_q[$];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  function automatic logic [W-1:0] src_word(input int i);
    case (i)
      0:       return a0;
      1:       return a1;
      2:       return a2;
      default: return a3;
    endcase
  endfunction

  task automatic model_reset();
    m_ptr   = 3;
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 2'd0;
    sb_q.delete();
  endtask

  // One clock: drive req/out_ready, check combinational gnt, then check the registered slot.
  task automatic cycle(input logic [3:0] r, input logic rdy);
    logic [3:0]   eg;
    logic [W+1:0] ent;
    int           idx;
    logic         free;
    req = r; out_ready = rdy;
    #1;
    free = !m_valid || rdy;
    idx  = -1;
    eg   = 4'b0000;
    if (free)
      for (int k = 1; k <= 4; k++)
        if (idx < 0 && r[(m_ptr + k) % 4]) idx = (m_ptr + k) % 4;
    if (idx >= 0) begin
      eg[idx] = 1'b1;
      sb_q.push_back({src_word(idx), 2'(idx)});
    end
    n_checks++;
    if (gnt !== eg) begin
      n_errors++;
      $display("FAIL gnt: got %b want %b (req=%b rdy=%b)", gnt, eg, r, rdy);
    end
    @(posedge clk); #1;
    if (idx >= 0) begin
      ent     = sb_q.pop_front();
      m_valid = 1'b1;
      m_ptr   = idx;
      m_data  = ent[W+1:2];
      m_sel   = ent[1:0];
    end else if (free) begin
      m_valid = 1'b0;
    end
    n_checks++;
    if (out_valid !== m_valid) begin
      n_errors++;
      $display("FAIL out_valid: got %b want %b", out_valid, m_valid);
    end
    if (m_valid) begin
      n_checks++;
      if (out_data !== m_data || sel !== m_sel) begin
        n_errors++;
        $display("FAIL slot: got data=%h sel=%0d want data=%h sel=%0d", out_data, sel, m_data, m_sel);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; lock = 4'b0000; out_ready = 1'b1;
    a0 = 32'h11111111; a1 = 32'h22222222; a2 = 32'h33333333; a3 = 32'h44444444;
    model_reset();
    #3;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || sel !== 2'd0 || gnt !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_state: got v=%b d=%h sel=%0d gnt=%b want 0/0/0/0", out_valid, out_data, sel, gnt);
    end
    req = 4'b0000;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel[5];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1);
      n_checks++;
      if (sel !== exp_sel[i] || out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL rr_order[%0d]: got sel=%0d v=%b want sel=%0d v=1", i, sel, out_valid, exp_sel[i]);
      end
    end
  endtask

  task automatic test_single();
    cycle(4'b0000, 1'b1);
    cycle(4'b0100, 1'b1);
    n_checks++;
    if (out_data !== 32'h33333333 || sel !== 2'd2) begin
      n_errors++;
      $display("FAIL single_src2: got d=%h sel=%0d want 33333333/2", out_data, sel);
    end
  endtask

  task automatic test_stall();
    logic [1:0] held;
    cycle(4'b1111, 1'b1);
    held = sel;
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b0);
    n_checks++;
    if (sel !== held) begin
      n_errors++;
      $display("FAIL stall_hold: got sel=%0d want %0d", sel, held);
    end
    cycle(4'b1111, 1'b1);
    n_checks++;
    if (sel !== held + 2'd1) begin
      n_errors++;
      $display("FAIL stall_release: got sel=%0d want %0d", sel, held + 2'd1);
    end
  endtask

  task automatic test_wrap();
    cycle(4'b0000, 1'b1);
    cycle(4'b1000, 1'b1);
    cycle(4'b1001, 1'b1);
    n_checks++;
    if (sel !== 2'd0) begin
      n_errors++;
      $display("FAIL wrap_to_0: got sel=%0d want 0", sel);
    end
    cycle(4'b1001, 1'b1);
    n_checks++;
    if (sel !== 2'd3) begin
      n_errors++;
      $display("FAIL wrap_to_3: got sel=%0d want 3", sel);
    end
    cycle(4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid();
    cycle(4'b0010, 1'b1);
    req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || sel !== 2'd0 || gnt !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_mid: got v=%b d=%h sel=%0d gnt=%b want 0/0/0/0", out_valid, out_data, sel, gnt);
    end
    req = 4'b0000;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    cycle(4'b1000, 1'b1);
    n_checks++;
    if (sel !== 2'd3 || out_data !== 32'h44444444) begin
      n_errors++;
      $display("FAIL reset_first: got sel=%0d d=%h want 3/44444444", sel, out_data);
    end
    cycle(4'b1111, 1'b1);
  endtask

  task automatic test_back_to_back();
    a0 = 32'hA0A0_0001; a1 = 32'hB1B1_0002; a2 = 32'hC2C2_0003; a3 = 32'hD3D3_0004;
    for (int i = 0; i < 12; i++) cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    cycle(4'b0000, 1'b1);
  endtask

`ifdef MUXARB_LOCK_EN
  task automatic test_lock();
    logic [3:0] exp_g[6];
    exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
    cycle(4'b0001, 1'b1);
    for (int i = 0; i < 6; i++) begin
      req = 4'b1111; out_ready = 1'b1;
      lock = (i < 3) ? 4'b0010 : 4'b0000;
      #1;
      n_checks++;
      if (gnt !== exp_g[i]) begin
        n_errors++;
        $display("FAIL lock_gnt[%0d]: got %b want %b", i, gnt, exp_g[i]);
      end
      @(posedge clk); #1;
    end
    lock = 4'b0000;
    m_valid = 1'b1; m_ptr = 3; m_data = a3; m_sel = 2'd3;
    cycle(4'b0000, 1'b1);
  endtask
`else
  task automatic test_lock_ignored();
    lock = 4'b0010;
    for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b1);
    lock = 4'b0000;
    cycle(4'b0000, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_wrap();
    test_reset_mid();
`ifdef MUXARB_LOCK_EN
    test_lock();
`else
    test_lock_ignored();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
